// File: rtl/player_cmd_gen.sv
// Per-player command front end: synchronizes and debounces raw button levels,
// resolves conflicts and emits frame-aligned movement pulses and action levels.
module player_cmd_gen #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16,
    parameter int JUMP_CD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [4:0] btn_raw,
    output logic       right,
    output logic       left,
    output logic       jump,
    output logic       squat,
    output logic       defend
);

    localparam int              CD_W     = (JUMP_CD < 1) ? 1 : $clog2(JUMP_CD + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = '1;
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(JUMP_CD);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] db;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_deb
        deb_state_t       state;
        deb_state_t       state_n;
        logic [DEB_W-1:0] cnt;
        logic [DEB_W-1:0] cnt_n;
        logic             db_q;
        logic             db_n;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_STABLE;
                cnt   <= '0;
                db_q  <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                db_q  <= db_n;
            end
        end

        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            db_n    = db_q;
            case (state)
                ST_STABLE: begin
                    if (sync2[i] != db_q) begin
                        if (cnt == DEB_LAST) begin
                            db_n = ~db_q;
                        end else begin
                            cnt_n   = cnt + 1'b1;
                            state_n = ST_CHANGING;
                        end
                    end
                end
                ST_CHANGING: begin
                    if (sync2[i] == db_q) begin
                        cnt_n   = '0;
                        state_n = ST_STABLE;
                    end else if (cnt == DEB_LAST) begin
                        db_n    = ~db_q;
                        cnt_n   = '0;
                        state_n = ST_STABLE;
                    end else if (cnt != DEB_MAX) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = ST_STABLE;
                end
            endcase
        end

        assign db[i] = db_q;
    end

    logic            db_jump_d;
    logic            jreq;
    logic            jreq_eff;
    logic            jump_fire;
    logic [CD_W-1:0] cd;

    // A press seen in the tick cycle itself is consumed by that tick.
    assign jreq_eff  = jreq | (db[2] & ~db_jump_d);
    assign jump_fire = frame_tick & jreq_eff & (cd == '0) & ~db[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_jump_d <= 1'b0;
            jreq      <= 1'b0;
            cd        <= '0;
            right     <= 1'b0;
            left      <= 1'b0;
            jump      <= 1'b0;
            squat     <= 1'b0;
            defend    <= 1'b0;
        end else begin
            db_jump_d <= db[2];
            jreq      <= frame_tick ? 1'b0 : jreq_eff;

            if (jump_fire) begin
                cd <= CD_LOAD;
            end else if (frame_tick && (cd != '0)) begin
                cd <= cd - 1'b1;
            end

            if (frame_tick) begin
                defend <= db[4];
                squat  <= db[3] & ~db[4];
                right  <= db[0] & ~db[1] & ~db[3] & ~db[4];
                left   <= db[1] & ~db[0] & ~db[3] & ~db[4];
                jump   <= jump_fire;
            end else begin
                right <= 1'b0;
                left  <= 1'b0;
                jump  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_cmd_gen.sv
// Scoreboard bench for player_cmd_gen: each driven cycle pushes the expected
// command vector, which is popped and compared one cycle later.
module tb_player_cmd_gen;

    localparam int DEB_CYCLES = 4;
    localparam int JUMP_CD    = 3;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       frame_tick = 1'b0;
    logic [4:0] btn_raw    = '0;
    logic       right;
    logic       left;
    logic       jump;
    logic       squat;
    logic       defend;

    typedef struct packed {
        logic right;
        logic left;
        logic jump;
        logic squat;
        logic defend;
    } cmd_t;

    typedef struct {
        cmd_t  cmd;
        string tag;
    } exp_t;

    exp_t       sb[$];
    int         checks       = 0;
    int         failures     = 0;
    int         phase        = 0;
    bit         force_tick   = 1'b0;
    bit         last_tick    = 1'b0;
    bit         sb_en        = 1'b0;
    bit         sb_live      = 1'b0;
    bit         jump_pending = 1'b0;
    logic [4:0] exp_btn      = '0;
    cmd_t       held         = '0;
    string      tag          = "idle";

    player_cmd_gen #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (16),
        .JUMP_CD   (JUMP_CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .btn_raw   (btn_raw),
        .right     (right),
        .left      (left),
        .jump      (jump),
        .squat     (squat),
        .defend    (defend)
    );

    always #5 clk = ~clk;

    // Priority table: defend wins, then squat, then a single move direction.
    function automatic cmd_t expect_cmd(input logic [4:0] b, input bit j);
        cmd_t c;
        c = '0;
        if (b[4]) begin
            c.defend = 1'b1;
        end else if (b[3]) begin
            c.squat = 1'b1;
        end else if (b[0] != b[1]) begin
            c.right = b[0];
            c.left  = b[1];
        end
        c.jump = j;
        return c;
    endfunction

    task automatic cyc();
        cmd_t got;
        exp_t e;
        @(negedge clk);
        got = {right, left, jump, squat, defend};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.cmd) begin
                failures++;
                $display("FAIL %s t=%0t: got r=%b l=%b j=%b s=%b d=%b, expected r=%b l=%b j=%b s=%b d=%b",
                         e.tag, $time, got.right, got.left, got.jump, got.squat, got.defend,
                         e.cmd.right, e.cmd.left, e.cmd.jump, e.cmd.squat, e.cmd.defend);
            end
        end
        frame_tick = (phase == 9) || force_tick;
        force_tick = 1'b0;
        phase      = (phase == 9) ? 0 : phase + 1;
        last_tick  = frame_tick;
        if (sb_en && (sb_live || frame_tick)) begin
            if (frame_tick) begin
                e.cmd        = expect_cmd(exp_btn, jump_pending);
                jump_pending = 1'b0;
                sb_live      = 1'b1;
                held         = e.cmd;
            end else begin
                e.cmd        = '0;
                e.cmd.squat  = held.squat;
                e.cmd.defend = held.defend;
            end
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // Advance until the cycle just driven carried a frame tick.
    task automatic align();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_tick && n < 20);
        checks++;
        if (!last_tick) begin
            failures++;
            $display("FAIL align: no frame tick within %0d cycles (got 0, required 1)", n);
        end
    endtask

    task automatic set_buttons(input logic [4:0] b);
        btn_raw = b;
        exp_btn = b;
    endtask

    task automatic test_reset();
        cmd_t got;
        tag = "reset_state";
        rst = 1'b1;
        run(3);
        got = {right, left, jump, squat, defend};
        checks++;
        if (got !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got %b, expected 00000", got);
        end

        // First tick lands before debounce completes; the next one sees right.
        tag     = "reset_latency";
        phase   = 7;
        rst     = 1'b0;
        btn_raw = 5'b00001;
        exp_btn = 5'b00000;
        sb_en   = 1'b1;
        align();
        exp_btn = 5'b00001;
        align();
        run(2);

        tag = "all_held";
        align();
        set_buttons(5'b11111);
        run(25);

        @(posedge clk);
        #2;
        rst     = 1'b1;
        sb_en   = 1'b0;
        sb_live = 1'b0;
        sb.delete();
        #1;
        got = {right, left, jump, squat, defend};
        checks++;
        if (got !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: got %b, expected 00000", got);
        end
        set_buttons(5'b00000);
        run(3);
        got = {right, left, jump, squat, defend};
        checks++;
        if (got !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b, expected 00000", got);
        end
        rst   = 1'b0;
        sb_en = 1'b1;
        tag   = "post_reset";
        run(12);
    endtask

    task automatic test_debounce();
        tag = "glitch";
        align();
        btn_raw[0] = 1'b1;
        run(3);
        btn_raw[0] = 1'b0;
        run(25);

        tag = "hold_right";
        align();
        set_buttons(5'b00001);
        run(30);
    endtask

    task automatic test_priority();
        logic [4:0] pats[6];
        pats = '{5'b00011, 5'b01001, 5'b11001, 5'b00010, 5'b01000, 5'b10000};
        foreach (pats[k]) begin
            tag = $sformatf("prio_%05b", pats[k]);
            align();
            set_buttons(pats[k]);
            run(20);
        end
        tag = "prio_clear";
        align();
        set_buttons(5'b00000);
        run(20);
    endtask

    task automatic test_jump_latch();
        tag = "jump_latch";
        align();
        btn_raw[2] = 1'b1;
        run(6);
        btn_raw[2]   = 1'b0;
        jump_pending = 1'b1;
        align();
        run(30);
    endtask

    task automatic test_cooldown();
        for (int f = 0; f < 6; f++) begin
            tag = $sformatf("cooldown_f%0d", f);
            align();
            btn_raw[2] = 1'b1;
            run(4);
            btn_raw[2]   = 1'b0;
            jump_pending = (f == 0) || (f == 4);
        end
        align();
        run(30);

        tag = "defend_jump";
        align();
        set_buttons(5'b10100);
        run(4);
        set_buttons(5'b10000);
        jump_pending = 1'b0;
        align();
        tag = "defend_jump_discard";
        set_buttons(5'b00000);
        align();
        run(20);
    endtask

    task automatic test_back_to_back();
        logic [4:0] pats[2];
        pats = '{5'b00001, 5'b01000};
        foreach (pats[k]) begin
            tag = $sformatf("b2b_%05b", pats[k]);
            align();
            set_buttons(pats[k]);
            align();
            force_tick = 1'b1;
            run(3);
            align();
            run(2);
        end
        set_buttons(5'b00000);
        run(25);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_priority();
        test_jump_latch();
        test_cooldown();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
